// File: rtl/t08_mem_arbiter_if.sv
// Handler-side request bus plus Wishbone manager and I2C result ports of t08_mem_arbiter.
// slave = arbiter view, master = handler/bus-environment view.
interface t08_mem_arbiter_if;
  logic        read_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        i2c_req_o;
  logic [31:0] i2c_rdata_i;
  logic        i2c_valid_i;

  modport slave (
    input  read_i, write_i, addr_i, wdata_i, wb_dat_i, wb_ack_i, i2c_rdata_i, i2c_valid_i,
    output rdata_o, busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
           i2c_req_o
  );

  modport master (
    output read_i, write_i, addr_i, wdata_i, wb_dat_i, wb_ack_i, i2c_rdata_i, i2c_valid_i,
    input  rdata_o, busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
           i2c_req_o
  );
endinterface

// File: rtl/t08_mem_arbiter.sv
// Routes single-outstanding handler requests to Wishbone or the read-only I2C result port; all outputs registered.
// Optional bus watchdog enabled by defining T08_BUS_TIMEOUT_EN (otherwise waits forever, err_o tied low).
module t08_mem_arbiter #(
  parameter logic [31:0] I2C_ADDR       = 32'd923923,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input logic              clk,
  input logic              nrst,
  t08_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_I2C  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_adr, w_adr_nxt;
  logic [31:0] r_dat, w_dat_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic        r_i2c_req, w_i2c_req_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_req;
  logic        w_hs;
  logic        w_abort;

  assign w_req = bus.read_i | bus.write_i;
  assign w_hs  = ((r_state == S_BUS) & bus.wb_ack_i) | ((r_state == S_I2C) & bus.i2c_valid_i);

`ifdef T08_BUS_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_inc;
  logic       r_err;

  // The counter sits at zero in IDLE, so it is always clear on entry to BUS/I2C.
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_abort   = ((r_state == S_BUS) || (r_state == S_I2C)) && !w_hs &&
                     (w_cnt_inc == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_cnt <= 8'd0;
      else                   r_cnt <= w_cnt_inc;
      if ((r_state == S_IDLE) && w_req) r_err <= 1'b0;
      else if (w_abort)                 r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign w_abort   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_adr     <= 32'd0;
      r_dat     <= 32'd0;
      r_rdata   <= 32'd0;
      r_cyc     <= 1'b0;
      r_i2c_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_we      <= w_we_nxt;
      r_adr     <= w_adr_nxt;
      r_dat     <= w_dat_nxt;
      r_rdata   <= w_rdata_nxt;
      r_cyc     <= w_cyc_nxt;
      r_i2c_req <= w_i2c_req_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_we_nxt      = r_we;
    w_adr_nxt     = r_adr;
    w_dat_nxt     = r_dat;
    w_rdata_nxt   = r_rdata;
    w_cyc_nxt     = r_cyc;
    w_i2c_req_nxt = r_i2c_req;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Writes always go to Wishbone, even at I2C_ADDR: the I2C port is read-only.
        if (bus.write_i) begin
          w_state_nxt = S_BUS;
          w_we_nxt    = 1'b1;
          w_adr_nxt   = bus.addr_i;
          w_dat_nxt   = bus.wdata_i;
          w_cyc_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end else if (bus.read_i) begin
          w_busy_nxt = 1'b1;
          if (bus.addr_i == I2C_ADDR) begin
            w_state_nxt   = S_I2C;
            w_i2c_req_nxt = 1'b1;
          end else begin
            w_state_nxt = S_BUS;
            w_we_nxt    = 1'b0;
            w_adr_nxt   = bus.addr_i;
            w_dat_nxt   = bus.wdata_i;
            w_cyc_nxt   = 1'b1;
          end
        end
      end

      S_BUS: begin
        if (bus.wb_ack_i || w_abort) begin
          if (!r_we) w_rdata_nxt = bus.wb_ack_i ? bus.wb_dat_i : 32'hDEAD_BEEF;
          w_state_nxt = S_RESP;
          w_cyc_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      S_I2C: begin
        if (bus.i2c_valid_i || w_abort) begin
          w_rdata_nxt   = bus.i2c_valid_i ? bus.i2c_rdata_i : 32'hDEAD_BEEF;
          w_state_nxt   = S_RESP;
          w_i2c_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rdata_o   = r_rdata;
  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.wb_cyc_o  = r_cyc;
  assign bus.wb_stb_o  = r_cyc;
  assign bus.wb_we_o   = r_we;
  assign bus.wb_adr_o  = r_adr;
  assign bus.wb_dat_o  = r_dat;
  assign bus.i2c_req_o = r_i2c_req;

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// Scoreboard bench for t08_mem_arbiter: random handler requests, modelled bus/I2C responders, decoupled monitor.
module tb_t08_mem_arbiter;
  localparam logic [31:0] I2C_ADDR = 32'd923923;
  localparam logic [7:0]  TO       = 8'd20;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  t08_mem_arbiter_if bus_if ();

  t08_mem_arbiter #(.I2C_ADDR(I2C_ADDR), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_if)
  );

  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; logic [31:0] rsp; int waits;} bus_txn_t;
  typedef struct {logic [31:0] rsp; int waits;} i2c_txn_t;
  typedef struct {logic [31:0] rdata; int lat; logic err;} exp_t;

  bus_txn_t    bus_q[$];
  i2c_txn_t    i2c_q[$];
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cycle = 0;
  bit          mon_en = 0;
  logic [31:0] model_rdata = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, expected one (cycle %0d)", nm, cycle);
  endtask

  // Reference model: write wins, reads of I2C_ADDR go to I2C, everything else to Wishbone.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rsp, input int waits);
    exp_t     e;
    bus_txn_t b;
    i2c_txn_t q;
    bit       timed;
    int       k;
    timed = 0;
`ifdef T08_BUS_TIMEOUT_EN
    if (waits >= int'(TO)) timed = 1;
`endif
    if (!wr && addr == I2C_ADDR) begin
      q.rsp = rsp; q.waits = waits;
      i2c_q.push_back(q);
    end else begin
      b.we = wr; b.adr = addr; b.dat = wdata; b.rsp = rsp; b.waits = waits;
      bus_q.push_back(b);
    end
    if (!wr) model_rdata = timed ? 32'hDEAD_BEEF : rsp;
    e.rdata = model_rdata;
    e.lat   = timed ? int'(TO) : waits + 1;
    e.err   = timed;
    exp_q.push_back(e);

    bus_if.read_i  = rd;
    bus_if.write_i = wr;
    bus_if.addr_i  = addr;
    bus_if.wdata_i = wdata;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_if.busy_o) break;
    end
    if (!bus_if.busy_o) bound_fail("accept");
    bus_if.read_i  = 1'b0;
    bus_if.write_i = 1'b0;
    bus_if.addr_i  = $urandom;
    bus_if.wdata_i = $urandom;
    k = 0;
    while (!bus_if.done_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!bus_if.done_o) bound_fail("done");
  endtask

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // Wishbone slave model
  initial begin
    bus_txn_t t;
    bit       act;
    int       cnt;
    act = 0; cnt = 0;
    t.we = 0; t.adr = 0; t.dat = 0; t.rsp = 0; t.waits = 0;
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        act = 0;
        bus_if.wb_ack_i = 1'b0;
        continue;
      end
      if (bus_if.wb_cyc_o) begin
        if (!act) begin
          act = 1;
          if (bus_q.size() == 0) begin
            check("unexpected_wb_cycle", bus_if.wb_cyc_o, 1'b0);
            t.we = 0; t.rsp = 0; t.waits = 100000;
          end else begin
            t = bus_q.pop_front();
            check("wb_we", bus_if.wb_we_o, t.we);
            check("wb_adr", bus_if.wb_adr_o, t.adr);
            if (t.we) check("wb_dat", bus_if.wb_dat_o, t.dat);
          end
          cnt = t.waits;
        end
        check("wb_stb", bus_if.wb_stb_o, 1'b1);
        check("i2c_idle_during_wb", bus_if.i2c_req_o, 1'b0);
        if (cnt == 0) begin
          bus_if.wb_ack_i = 1'b1;
          bus_if.wb_dat_i = t.rsp;
        end else begin
          cnt--;
          bus_if.wb_ack_i = 1'b0;
          bus_if.wb_dat_i = $urandom;
        end
      end else begin
        act = 0;
        bus_if.wb_ack_i = ($urandom_range(0, 3) == 0);
        bus_if.wb_dat_i = $urandom;
      end
    end
  end

  // I2C result port model
  initial begin
    i2c_txn_t t;
    bit       act;
    int       cnt;
    act = 0; cnt = 0;
    t.rsp = 0; t.waits = 0;
    bus_if.i2c_valid_i = 1'b0;
    bus_if.i2c_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        act = 0;
        bus_if.i2c_valid_i = 1'b0;
        continue;
      end
      if (bus_if.i2c_req_o) begin
        if (!act) begin
          act = 1;
          if (i2c_q.size() == 0) begin
            check("unexpected_i2c_req", bus_if.i2c_req_o, 1'b0);
            t.rsp = 0; t.waits = 100000;
          end else begin
            t = i2c_q.pop_front();
          end
          cnt = t.waits;
        end
        check("wb_idle_during_i2c", bus_if.wb_cyc_o, 1'b0);
        if (cnt == 0) begin
          bus_if.i2c_valid_i = 1'b1;
          bus_if.i2c_rdata_i = t.rsp;
        end else begin
          cnt--;
          bus_if.i2c_valid_i = 1'b0;
          bus_if.i2c_rdata_i = $urandom;
        end
      end else begin
        act = 0;
        bus_if.i2c_valid_i = ($urandom_range(0, 3) == 0);
        bus_if.i2c_rdata_i = $urandom;
      end
    end
  end

  // Completion monitor
  initial begin
    int   start_c;
    bit   prev_busy;
    bit   prev_done;
    exp_t e;
    start_c = 0; prev_busy = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (!nrst || !mon_en) begin
        prev_busy = 0;
        prev_done = 0;
        continue;
      end
      if (prev_done) begin
        check("done_one_cycle", bus_if.done_o, 1'b0);
        check("resp_ignores_req", bus_if.busy_o, 1'b0);
      end
      if (bus_if.busy_o && !prev_busy) start_c = cycle;
      if (bus_if.done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus_if.done_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", bus_if.rdata_o, e.rdata);
          check("latency", cycle - start_c, e.lat);
          check("err", bus_if.err_o, e.err);
          check("busy_at_done", bus_if.busy_o, 1'b0);
          check("cyc_at_done", bus_if.wb_cyc_o, 1'b0);
          check("req_at_done", bus_if.i2c_req_o, 1'b0);
        end
      end
      prev_busy = bus_if.busy_o;
      prev_done = bus_if.done_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    int          wt;
    int          k;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] r;
    bus_txn_t    b;

    bus_if.read_i  = 1'b0;
    bus_if.write_i = 1'b0;
    bus_if.addr_i  = 32'd0;
    bus_if.wdata_i = 32'd0;

    #12;
    check("rst_rdata", bus_if.rdata_o, 32'd0);
    check("rst_busy", bus_if.busy_o, 1'b0);
    check("rst_done", bus_if.done_o, 1'b0);
    check("rst_err", bus_if.err_o, 1'b0);
    check("rst_cyc", bus_if.wb_cyc_o, 1'b0);
    check("rst_stb", bus_if.wb_stb_o, 1'b0);
    check("rst_we", bus_if.wb_we_o, 1'b0);
    check("rst_adr", bus_if.wb_adr_o, 32'd0);
    check("rst_i2c_req", bus_if.i2c_req_o, 1'b0);
    @(negedge clk);
    nrst   = 1'b1;
    mon_en = 1;
    @(negedge clk);

    issue(0, 1, 32'h100, 32'hCAFE_F00D, 32'h0, 0);
    issue(1, 0, 32'h40, 32'h0, 32'h1234_5678, 3);
    issue(1, 0, I2C_ADDR, 32'h0, 32'h0000_00A5, 2);
    issue(1, 1, I2C_ADDR, 32'h5A5A_0001, 32'h0BAD_0BAD, 1);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      w    = $urandom;
      r    = $urandom;
      wt   = $urandom_range(0, 6);
      case (kind)
        0:       issue(0, 1, ($urandom_range(0, 3) == 0) ? I2C_ADDR : a, w, r, wt);
        1:       issue(1, 0, a, w, r, wt);
        2:       issue(1, 0, I2C_ADDR, w, r, wt);
        default: issue(1, 1, ($urandom_range(0, 1) == 0) ? I2C_ADDR : a, w, r, wt);
      endcase
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

`ifdef T08_BUS_TIMEOUT_EN
    issue(1, 0, 32'h200, 32'h0, 32'h7777_7777, 1000);
    issue(0, 1, 32'h204, 32'h1357_9BDF, 32'h0, 0);
`endif

    // Asynchronous reset in the middle of a Wishbone read
    issue(1, 0, 32'h44, 32'h0, 32'h0BAD_F00D, 0);
    b.we = 0; b.adr = 32'h300; b.dat = 32'h0; b.rsp = 32'h1111_1111; b.waits = 50;
    bus_q.push_back(b);
    bus_if.read_i = 1'b1;
    bus_if.addr_i = 32'h300;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_if.busy_o) break;
    end
    bus_if.read_i = 1'b0;
    repeat (3) @(negedge clk);
    check("cyc_before_reset", bus_if.wb_cyc_o, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_cyc", bus_if.wb_cyc_o, 1'b0);
    check("arst_stb", bus_if.wb_stb_o, 1'b0);
    check("arst_busy", bus_if.busy_o, 1'b0);
    check("arst_rdata", bus_if.rdata_o, 32'd0);
    check("arst_done", bus_if.done_o, 1'b0);
    model_rdata = 32'd0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset_busy", bus_if.busy_o, 1'b0);
      check("idle_after_reset_cyc", bus_if.wb_cyc_o, 1'b0);
    end
    issue(0, 1, 32'h400, 32'h2468_ACE0, 32'h0, 0);
    issue(1, 0, I2C_ADDR, 32'h0, 32'h0000_0042, 1);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("i2c_q_drained", i2c_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/t08_mem_arbiter.md
# t08_mem_arbiter

Memory-side bus arbiter for the team 08 core, directly downstream of the load/store/fetch handler. Accepts the handler's single-outstanding read/write requests (address, write data, read/write strobes) and routes them either to the Wishbone manager port (RAM and general MMIO) or to the I2C result register. It returns read data, a `busy` level that stalls the handler, and a one-cycle `done` pulse. An optional watchdog aborts hung bus transactions.

## Interface
Parameters:
- `I2C_ADDR`, default `32'd923923`: read address serviced by the I2C port.
- `TIMEOUT_CYCLES`, default `255`: watchdog limit in cycles, 8-bit counter; only used when `T08_BUS_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `read_i` in 1: read request from handler (level, sampled in IDLE).
- `write_i` in 1: write request from handler (level, sampled in IDLE).
- `addr_i` in 32: request byte address.
- `wdata_i` in 32: write data, already width-formatted by handler.
- `rdata_o` out 32: read data, held until the next completed read.
- `busy_o` out 1: arbiter cannot accept a request.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky timeout flag.
- `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_we_o` out 1: Wishbone cycle, strobe, write-enable.
- `wb_adr_o` out 32, `wb_dat_o` out 32: Wishbone address and write data.
- `wb_dat_i` in 32, `wb_ack_i` in 1: Wishbone read data and acknowledge.
- `i2c_req_o` out 1: I2C result read request (level).
- `i2c_rdata_i` in 32, `i2c_valid_i` in 1: I2C result data and valid.

## Operation
- States: IDLE, BUS, I2C, RESP. All outputs are registered.
- IDLE: if `write_i` is high, latch `addr_i`/`wdata_i`, set `we=1`, go to BUS. Write has priority when both strobes are high. Else if `read_i` is high: go to I2C when `addr_i == I2C_ADDR`, otherwise latch the request with `we=0` and go to BUS.
- Writes to `I2C_ADDR` go to BUS; the I2C port is read-only.
- BUS: drive `wb_cyc_o = wb_stb_o = 1`, `wb_we_o = we`, and the latched address/data. On `wb_ack_i`: if read, capture `wb_dat_i` into `rdata_o`; drop cyc/stb the next cycle; go to RESP.
- I2C: drive `i2c_req_o = 1`. On `i2c_valid_i`: capture `i2c_rdata_i` into `rdata_o`; go to RESP.
- RESP: `done_o = 1` for exactly one cycle, then go to IDLE unconditionally.
- `busy_o = 1` in BUS and I2C and 0 in IDLE and RESP. Requests presented during RESP are ignored; they are re-sampled in IDLE.
- `wb_ack_i` and `i2c_valid_i` are ignored outside their own state.
- `err_o` is cleared when the next request is accepted in IDLE.
- Reset values: all outputs 0, including `rdata_o`, `busy_o`, `done_o`, `err_o`, and all bus strobes. State resets to IDLE.
- Asserting reset mid-transaction drops cyc/stb/req asynchronously, and no `done_o` is produced.

## Timing
- Request accepted at edge N (state leaves IDLE). `busy_o` and the bus strobes are high from N+1.
- If `wb_ack_i` is high in the first BUS cycle (N+1), the state is RESP and `done_o` is high at N+2. General latency is `2 + wait_cycles` edges from acceptance to `done_o`.
- `rdata_o` is valid in the same cycle `done_o` is high, and stable until the next read completes.
- Back-to-back throughput is one request per 3 cycles minimum (IDLE, BUS, RESP).

## Configuration
- `T08_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter is cleared on entry to BUS or I2C and increments each cycle waiting.
  - When it reaches `TIMEOUT_CYCLES` with no ack/valid: drop strobes, set `rdata_o = 32'hDEAD_BEEF` (reads only), set `err_o = 1`, go to RESP (which pulses `done_o`).
- `T08_BUS_TIMEOUT_EN` not defined: there is no counter, the arbiter waits indefinitely, and `err_o` is tied to 0.

## Test plan
- Write `addr=0x100`, `wdata=0xCAFEF00D`, ack on the first BUS cycle: `wb_we_o=1`, `wb_adr_o=0x100`, `wb_dat_o=0xCAFEF00D`; `done_o` pulses at N+2; `rdata_o` unchanged.
- Read `addr=0x40`, ack after 3 wait cycles with `wb_dat_i=0x12345678`: `busy_o` high 4 cycles; `done_o` at N+5; `rdata_o=0x12345678`.
- Read `addr=923923` with `i2c_valid_i` after 2 cycles, `i2c_rdata_i=0xA5`: Wishbone `cyc` stays 0 throughout; `rdata_o=0x000000A5`; `done_o` pulses once.
- `read_i` and `write_i` both high at `addr=923923`: the write wins and goes to BUS with `wb_we_o=1`; `i2c_req_o` stays 0.
- With the macro defined and no ack for 255 cycles: strobes drop, `err_o=1`, `rdata_o=0xDEADBEEF`, `done_o` pulses. The next request clears `err_o`.
- `nrst` asserted during BUS: `wb_cyc_o`, `busy_o`, and `rdata_o` go to 0 immediately; the state is IDLE after release.
